// File: rtl/mac_config_loader.sv
// mac_config_loader: serial configuration loader for the MAC cluster array.
// Hunts a sync byte, shifts a framed payload into a shadow register, then
// commits it to the live configuration only if the 8-bit ones-count checksum
// matches, so clusters never observe a partially loaded configuration.
module mac_config_loader #(
    parameter int unsigned NUM_CLUSTERS = 1,
    parameter int unsigned CFG_BITS     = 16,
    parameter logic [7:0]  SYNC         = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             config_en,
    input  logic                             config_in,
    output logic [NUM_CLUSTERS*CFG_BITS-1:0] cfg_word,
    output logic                             cfg_valid,
    output logic                             cfg_update,
    output logic                             busy,
    output logic                             config_err
);

    localparam int unsigned TOTAL   = NUM_CLUSTERS * CFG_BITS;
    localparam int unsigned CNT_MAX = (TOTAL > 8) ? TOTAL : 8;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state, state_d;
    // Only the 7 most recent bits are stored; the 8th is the live input bit.
    logic [6:0]         sync_sr, sync_sr_d;
    logic [6:0]         chk, chk_d;
    logic [TOTAL-1:0]   shadow, shadow_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [7:0]         ones_cnt, ones_cnt_d;
    logic [TOTAL-1:0]   cfg_word_d;
    logic               cfg_valid_d, cfg_update_d, busy_d, config_err_d;
    logic [7:0]         sync_win, chk_win;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            sync_sr    <= '0;
            chk        <= '0;
            shadow     <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            cfg_word   <= '0;
            cfg_valid  <= 1'b0;
            cfg_update <= 1'b0;
            busy       <= 1'b0;
            config_err <= 1'b0;
        end else begin
            state      <= state_d;
            sync_sr    <= sync_sr_d;
            chk        <= chk_d;
            shadow     <= shadow_d;
            bit_cnt    <= bit_cnt_d;
            ones_cnt   <= ones_cnt_d;
            cfg_word   <= cfg_word_d;
            cfg_valid  <= cfg_valid_d;
            cfg_update <= cfg_update_d;
            busy       <= busy_d;
            config_err <= config_err_d;
        end
    end

    // Next-state, shift/count updates and commit decision; idle when config_en=0.
    always_comb begin
        state_d      = state;
        sync_sr_d    = sync_sr;
        chk_d        = chk;
        shadow_d     = shadow;
        bit_cnt_d    = bit_cnt;
        ones_cnt_d   = ones_cnt;
        cfg_word_d   = cfg_word;
        cfg_valid_d  = cfg_valid;
        cfg_update_d = 1'b0;
        config_err_d = config_err;
        sync_win     = {sync_sr, config_in};
        chk_win      = {chk, config_in};

        if (config_en) begin
            unique case (state)
                HUNT: begin
                    sync_sr_d = sync_win[6:0];
                    if (sync_win == SYNC) begin
                        state_d    = LOAD;
                        bit_cnt_d  = '0;
                        ones_cnt_d = '0;
                        sync_sr_d  = '0;
                    end
                end
                LOAD: begin
                    shadow_d   = TOTAL'({shadow, config_in});
                    ones_cnt_d = ones_cnt + 8'(config_in);
                    if (bit_cnt == CNT_W'(TOTAL - 1)) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    chk_d = chk_win[6:0];
                    if (bit_cnt == CNT_W'(7)) begin
                        state_d   = HUNT;
                        bit_cnt_d = '0;
                        if (chk_win == ones_cnt) begin
                            cfg_word_d   = shadow;
                            cfg_valid_d  = 1'b1;
                            cfg_update_d = 1'b1;
                            config_err_d = 1'b0;
                        end else begin
                            config_err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        busy_d = (state_d != HUNT);
    end

endmodule

// File: tb/tb_mac_config_loader.sv
// Directed bench for mac_config_loader: frames are driven bit-serially, the
// expected committed word is queued per good frame and popped when cfg_update
// pulses.
module tb_mac_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        config_en;
    logic        config_in;
    logic [15:0] cfg_word;
    logic        cfg_valid;
    logic        cfg_update;
    logic        busy;
    logic        config_err;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_updates = 0;
    logic [15:0] exp_q[$];
    logic        prev_upd = 1'b0;

    mac_config_loader #(
        .NUM_CLUSTERS(1),
        .CFG_BITS    (16),
        .SYNC        (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .config_en (config_en),
        .config_in (config_in),
        .cfg_word  (cfg_word),
        .cfg_valid (cfg_valid),
        .cfg_update(cfg_update),
        .busy      (busy),
        .config_err(config_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every cfg_update pulse must match the oldest queued good frame.
    always @(posedge clk) begin
        #1;
        if (prev_upd) check("update_one_cycle", 32'(cfg_update), 32'd0);
        if (cfg_update === 1'b1) begin
            n_updates++;
            check("update_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("commit_word", 32'(cfg_word), 32'(exp_q.pop_front()));
        end
        prev_upd = (cfg_update === 1'b1);
    end

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            config_en = 1'b1;
            config_in = v[i];
        end
    endtask

    task automatic gap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            config_en = 1'b0;
            config_in = 1'($urandom);
            @(posedge clk);
            #1;
            check(tag, 32'(busy), 32'd1);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            config_en = 1'b0;
            config_in = 1'b0;
        end
    endtask

    int upd_base;

    initial begin
        rst       = 1'b1;
        config_en = 1'b0;
        config_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_word", 32'(cfg_word), 32'h0);
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_update", 32'(cfg_update), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(config_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: good frame
        exp_q.push_back(16'h1234);
        send_bits(16'h00A5, 8);
        settle();
        check("t1_busy_after_sync", 32'(busy), 32'd1);
        send_bits(16'h1234, 16);
        send_bits(16'h0005, 8);
        settle();
        check("t1_word", 32'(cfg_word), 32'h1234);
        check("t1_valid", 32'(cfg_valid), 32'd1);
        check("t1_update", 32'(cfg_update), 32'd1);
        check("t1_err", 32'(config_err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        idle(3);
        check("t1_pulses", 32'(n_updates), 32'd1);

        // Test 2: bad checksum
        send_bits(16'h00A5, 8);
        send_bits(16'h1234, 16);
        send_bits(16'h0006, 8);
        settle();
        check("t2_err", 32'(config_err), 32'd1);
        check("t2_word", 32'(cfg_word), 32'h1234);
        check("t2_valid", 32'(cfg_valid), 32'd1);
        check("t2_update", 32'(cfg_update), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        idle(3);
        check("t2_pulses", 32'(n_updates), 32'd1);

        // Test 3: gapped frame
        exp_q.push_back(16'h1234);
        send_bits(16'h00A5, 8);
        send_bits(16'h0012, 8);
        gap(3, "t3_busy_gap_payload");
        send_bits(16'h0034, 8);
        send_bits(16'h0000, 4);
        gap(3, "t3_busy_gap_chk");
        send_bits(16'h0005, 4);
        settle();
        check("t3_word", 32'(cfg_word), 32'h1234);
        check("t3_err", 32'(config_err), 32'd0);
        check("t3_update", 32'(cfg_update), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        idle(3);
        check("t3_pulses", 32'(n_updates), 32'd2);

        // Test 4: false-start noise before the real sync byte
        exp_q.push_back(16'h00FF);
        send_bits(16'h00F5, 8);
        settle();
        check("t4_noise_not_sync", 32'(busy), 32'd0);
        send_bits(16'h00A5, 8);
        send_bits(16'h00FF, 16);
        send_bits(16'h0008, 8);
        settle();
        check("t4_word", 32'(cfg_word), 32'h00FF);
        check("t4_err", 32'(config_err), 32'd0);
        idle(3);
        check("t4_pulses", 32'(n_updates), 32'd3);

        // Test 5: asynchronous reset mid-payload
        send_bits(16'h00A5, 8);
        send_bits(16'h0040, 7);
        settle();
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_word", 32'(cfg_word), 32'h0);
        check("t5_rst_valid", 32'(cfg_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_err", 32'(config_err), 32'd0);
        check("t5_rst_update", 32'(cfg_update), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(16'h8001);
        send_bits(16'h00A5, 8);
        send_bits(16'h8001, 16);
        send_bits(16'h0002, 8);
        settle();
        check("t5_word", 32'(cfg_word), 32'h8001);
        check("t5_valid", 32'(cfg_valid), 32'd1);
        idle(3);
        check("t5_pulses", 32'(n_updates), 32'd4);

        // Test 6: back-to-back frames
        upd_base = n_updates;
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'h0001);
        send_bits(16'h00A5, 8);
        send_bits(16'hAAAA, 16);
        send_bits(16'h0008, 8);
        send_bits(16'h00A5, 8);
        send_bits(16'h0001, 16);
        send_bits(16'h0001, 8);
        settle();
        check("t6_word", 32'(cfg_word), 32'h0001);
        check("t6_err", 32'(config_err), 32'd0);
        idle(3);
        check("t6_pulses", 32'(n_updates - upd_base), 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
